// File: rtl/aie_trip_eval.sv
// Interlock scan evaluator: one sample per ID on the generator write edge, 2-clk compare pipeline, bitmap published at end of scan.
// No backpressure; trig during a scan aborts it. Build with AIE_DEBOUNCE_EN to require TRIP_CNT consecutive tripped scans per ID.
module aie_trip_eval #(
  parameter int MAX_ID_NUM = 60,
  parameter int DW         = 32,
  parameter int TRIP_CNT   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic [6:0]    aie_addr,
  input  logic          wr,
  input  logic          mask,
  input  logic          mask2,
  input  logic [DW-1:0] pos_x,
  input  logic [DW-1:0] pos_y,
  input  logic [DW-1:0] lim_x,
  input  logic [DW-1:0] lim_y,
  input  logic          trip_clr,
  output logic [63:0]   trip_bm,
  output logic          trip_out,
  output logic [6:0]    first_id,
  output logic          scan_done,
  output logic [7:0]    scan_err
);
  localparam logic [6:0] MAX_A = 7'(MAX_ID_NUM);
  localparam logic [6:0] NO_ID = 7'h7F;

  if (MAX_ID_NUM < 1 || MAX_ID_NUM > 64 || TRIP_CNT < 1) begin : g_bad_cfg
    $error("aie_trip_eval: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        state;
  logic          wr_d;
  logic          drain_cnt;
  logic          s1_vld;
  logic          s1_mask2;
  logic [5:0]    s1_addr;
  logic [DW-1:0] s1_ax, s1_ay, s1_lx, s1_ly;
  logic [63:0]   cur_bm;
  logic [63:0]   qual_bm;
  logic [6:0]    low_id;
  logic          sample;
  logic          hit;

  // Most negative input has no positive twin; clamp it to the largest magnitude.
  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
    if (!v[DW-1]) return v;
    if (v == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    return ~v + DW'(1);
  endfunction

  assign sample = (state == SCAN) && !trig && wr && !wr_d && mask && (aie_addr < MAX_A);
  assign hit    = (s1_ax > s1_lx) || (s1_mask2 && (s1_ay > s1_ly));

`ifdef AIE_DEBOUNCE_EN
  localparam int CW = $clog2(TRIP_CNT + 1);
  logic [CW-1:0] cnt [64];

  // An ID qualifies when this scan's hit brings its streak to TRIP_CNT.
  always_comb begin
    qual_bm = '0;
    for (int i = 0; i < 64; i++)
      qual_bm[i] = cur_bm[i] && ((int'(cnt[i]) + 1) >= TRIP_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) cnt[i] <= '0;
    end else if (trip_clr) begin
      for (int i = 0; i < 64; i++) cnt[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < 64; i++) begin
        if (!cur_bm[i])                     cnt[i] <= '0;
        else if (int'(cnt[i]) < TRIP_CNT)   cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
`else
  assign qual_bm = cur_bm;
`endif

  always_comb begin
    low_id = NO_ID;
    for (int i = 63; i >= 0; i--)
      if (qual_bm[i]) low_id = 7'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_d      <= 1'b0;
      drain_cnt <= 1'b0;
      s1_vld    <= 1'b0;
      s1_mask2  <= 1'b0;
      s1_addr   <= '0;
      s1_ax     <= '0;
      s1_ay     <= '0;
      s1_lx     <= '0;
      s1_ly     <= '0;
      cur_bm    <= '0;
      trip_bm   <= '0;
      trip_out  <= 1'b0;
      first_id  <= NO_ID;
      scan_done <= 1'b0;
      scan_err  <= '0;
    end else begin
      wr_d      <= wr;
      scan_done <= 1'b0;
      s1_vld    <= sample;
      if (sample) begin
        s1_addr  <= aie_addr[5:0];
        s1_mask2 <= mask2;
        s1_ax    <= abs_sat(pos_x);
        s1_ay    <= abs_sat(pos_y);
        s1_lx    <= lim_x;
        s1_ly    <= lim_y;
      end
      if (s1_vld && hit) cur_bm[s1_addr] <= 1'b1;

      case (state)
        IDLE: begin
          if (trig) begin
            state  <= SCAN;
            cur_bm <= '0;
          end
        end
        SCAN, DRAIN: begin
          if (trig) begin
            state  <= SCAN;
            cur_bm <= '0;
            s1_vld <= 1'b0;
            if (scan_err != 8'hFF) scan_err <= scan_err + 8'd1;
          end else if (state == SCAN) begin
            if (aie_addr >= MAX_A) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end else if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          trip_bm   <= cur_bm;
          scan_done <= 1'b1;
          if (trig) begin
            state  <= SCAN;
            cur_bm <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A trip published in DONE beats a simultaneous operator clear.
      if (state == DONE && |qual_bm) begin
        trip_out <= 1'b1;
        if (trip_clr || first_id == NO_ID) first_id <= low_id;
      end else if (trip_clr) begin
        trip_out <= 1'b0;
        first_id <= NO_ID;
      end
    end
  end
endmodule

// File: tb/tb_aie_trip_eval.sv
// Directed bench for aie_trip_eval: scan-level reference model compared every cycle, plus literal expectations.
module tb_aie_trip_eval;
  localparam int MAXN = 60;
  localparam int TCNT = 3;
`ifdef AIE_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic        clk;
  logic        reset, trig, wr, mask, mask2, trip_clr;
  logic [6:0]  aie_addr;
  logic [31:0] pos_x, pos_y, lim_x, lim_y;
  logic [63:0] trip_bm;
  logic        trip_out, scan_done;
  logic [6:0]  first_id;
  logic [7:0]  scan_err;

  aie_trip_eval #(.MAX_ID_NUM(MAXN), .DW(32), .TRIP_CNT(TCNT)) dut (
    .clk(clk), .reset(reset), .trig(trig), .aie_addr(aie_addr), .wr(wr),
    .mask(mask), .mask2(mask2), .pos_x(pos_x), .pos_y(pos_y),
    .lim_x(lim_x), .lim_y(lim_y), .trip_clr(trip_clr), .trip_bm(trip_bm),
    .trip_out(trip_out), .first_id(first_id), .scan_done(scan_done),
    .scan_err(scan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-scan stimulus table
  int     tpx [MAXN];
  int     tpy [MAXN];
  longint tlx [MAXN];
  longint tly [MAXN];
  bit     tmk [MAXN];
  bit     tmk2[MAXN];
  int     thold[MAXN];

  // Reference model state
  logic [63:0] m_cur, m_bm;
  bit          m_trip, m_done, m_active, chk_en;
  logic [6:0]  m_first;
  int          m_err;
  int          streak[64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint mabs(input longint v);
    longint r;
    r = (v < 0) ? -v : v;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("trip_bm", trip_bm, m_bm);
      chk("trip_out", 64'(trip_out), 64'(m_trip));
      chk("first_id", 64'(first_id), 64'(m_first));
      chk("scan_err", 64'(scan_err), 64'(m_err));
      chk("scan_done", 64'(scan_done), 64'(m_done));
    end
  end

  task automatic fill_default();
    for (int i = 0; i < MAXN; i++) begin
      tpx[i] = 100; tpy[i] = 0; tlx[i] = 200; tly[i] = 200;
      tmk[i] = 1'b1; tmk2[i] = 1'b0; thold[i] = 1;
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    if (m_active && m_err < 255) m_err++;
    m_cur = '0;
    m_active = 1'b1;
  endtask

  task automatic wr_id(input int i);
    aie_addr = 7'(i); mask = tmk[i]; mask2 = tmk2[i];
    pos_x = tpx[i]; pos_y = tpy[i]; lim_x = 32'(tlx[i]); lim_y = 32'(tly[i]);
    wr = 1'b1;
    repeat (thold[i]) begin @(posedge clk); #1; end
    wr = 1'b0;
    @(posedge clk); #1;
    if (tmk[i] && ((mabs(longint'(tpx[i])) > tlx[i]) ||
                   (tmk2[i] && (mabs(longint'(tpy[i])) > tly[i]))))
      m_cur[i] = 1'b1;
  endtask

  task automatic publish(input bit clr);
    logic [63:0] q;
    logic [6:0]  low;
    q = '0;
    low = 7'h7F;
    for (int i = 0; i < 64; i++) begin
      if (DEB) begin
        streak[i] = m_cur[i] ? ((streak[i] < TCNT) ? streak[i] + 1 : TCNT) : 0;
        q[i] = m_cur[i] && (streak[i] >= TCNT);
      end else begin
        q[i] = m_cur[i];
      end
      if (clr) streak[i] = 0;
    end
    for (int i = 63; i >= 0; i--) if (q[i]) low = 7'(i);
    m_bm = m_cur;
    if (q != 0) begin
      m_trip = 1'b1;
      if (clr || m_first == 7'h7F) m_first = low;
    end else if (clr) begin
      m_trip = 1'b0;
      m_first = 7'h7F;
    end
    m_done = 1'b1;
  endtask

  // Out-of-range slot marks end of scan; optional wr=1 with tripping data there must be ignored.
  task automatic end_scan(input bit clr, input bit end_wr);
    aie_addr = 7'(MAXN); mask = 1'b1; mask2 = 1'b1;
    pos_x = 32'hFFFF_0000; lim_x = 32'd0; wr = end_wr;
    repeat (3) @(posedge clk);
    #1;
    trip_clr = clr;
    @(posedge clk); #1;
    trip_clr = 1'b0;
    wr = 1'b0;
    m_active = 1'b0;
    publish(clr);
    @(posedge clk); #1;
    m_done = 1'b0;
  endtask

  task automatic run_scan(input bit clr, input bit end_wr);
    pulse_trig();
    for (int i = 0; i < MAXN; i++) wr_id(i);
    end_scan(clr, end_wr);
  endtask

  task automatic partial_scan(input int n);
    pulse_trig();
    for (int i = 0; i < n; i++) wr_id(i);
    aie_addr = 7'(n);
  endtask

  task automatic clear_trip();
    trip_clr = 1'b1;
    @(posedge clk); #1;
    trip_clr = 1'b0;
    m_trip = 1'b0;
    m_first = 7'h7F;
    for (int i = 0; i < 64; i++) streak[i] = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; trig = 1'b0; wr = 1'b0; mask = 1'b0; mask2 = 1'b0; trip_clr = 1'b0;
    aie_addr = '0; pos_x = '0; pos_y = '0; lim_x = '0; lim_y = '0;
    m_cur = '0; m_bm = '0; m_trip = 1'b0; m_done = 1'b0; m_active = 1'b0;
    m_first = 7'h7F; m_err = 0; chk_en = 1'b0;
    for (int i = 0; i < 64; i++) streak[i] = 0;
    #2 reset = 1'b0;
    #10;
    chk("rst_trip_bm", trip_bm, 64'h0);
    chk("rst_trip_out", 64'(trip_out), 64'h0);
    chk("rst_first_id", 64'(first_id), 64'h7F);
    chk("rst_scan_done", 64'(scan_done), 64'h0);
    chk("rst_scan_err", 64'(scan_err), 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Clean scan
    fill_default();
    run_scan(1'b0, 1'b0);
    chk("A_bm", trip_bm, 64'h0);
    chk("A_trip", 64'(trip_out), 64'h0);
    chk("A_first", 64'(first_id), 64'h7F);

    // ID 5 trips on X; ID 12 sits exactly on the Y limit
    fill_default();
    tpx[5] = -300;
    tmk2[12] = 1'b1; tpy[12] = 250; tly[12] = 250;
    run_scan(1'b0, 1'b0);
    chk("B_bm", trip_bm, 64'h20);
    chk("B_trip", 64'(trip_out), DEB ? 64'h0 : 64'h1);
    chk("B_first", 64'(first_id), DEB ? 64'h7F : 64'h5);

    // Y excess with mask2=0, X excess on a masked ID, write at out-of-range slot
    fill_default();
    tpy[7] = 900; tly[7] = 10;
    tmk[9] = 1'b0; tpx[9] = 5000;
    run_scan(1'b0, 1'b1);
    chk("C_bm", trip_bm, 64'h0);

    // Long write window on ID 3 at the negative extreme; ID 4 equals the clamped magnitude
    fill_default();
    thold[3] = 36; tpx[3] = 32'h8000_0000; tlx[3] = 64'd2147483646;
    tpx[4] = 32'h8000_0000; tlx[4] = 64'd2147483647;
    run_scan(1'b0, 1'b0);
    chk("D_bm", trip_bm, 64'h8);

    // Abort at slot 30, then a full scan with a clear coinciding with its tripping DONE
    fill_default();
    tpx[20] = -999;
    partial_scan(30);
    fill_default();
    tpx[40] = 1000;
    run_scan(1'b1, 1'b0);
    chk("E_err", 64'(scan_err), 64'h1);
    chk("E_bm", trip_bm, 64'h0000_0100_0000_0000);
    chk("E_trip", 64'(trip_out), DEB ? 64'h0 : 64'h1);
    chk("E_first", 64'(first_id), DEB ? 64'h7F : 64'd40);

    clear_trip();
    @(posedge clk); #1;
    chk("F_trip", 64'(trip_out), 64'h0);
    chk("F_first", 64'(first_id), 64'h7F);

    // ID 2 pattern across six scans: hit, hit, clean, hit, hit, hit
    for (int s = 1; s <= 6; s++) begin
      fill_default();
      if (s != 3) tpx[2] = 500;
      run_scan(1'b0, 1'b0);
      if (s == 5) chk("G5_trip", 64'(trip_out), DEB ? 64'h0 : 64'h1);
    end
    chk("G6_trip", 64'(trip_out), 64'h1);
    chk("G6_first", 64'(first_id), 64'h2);
    chk("G6_bm", trip_bm, 64'h4);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aie_trip_eval.md
Name: aie_trip_eval

Overview:
- Downstream consumer of the interlock address generator; one evaluator per interlock scan.
- For each ID slot 0..MAX_ID_NUM-1 it samples position and limit data on the generator's write strobe, compares absolute position against the limit, and builds a per-ID trip bitmap.
- At end of scan it publishes the bitmap, a sticky trip output to the beam-permit logic, and the first-faulting ID.

Parameters:
- MAX_ID_NUM, 60, number of ID slots per scan; must be <= 64.
- DW, 32, signed width of position and limit data.
- TRIP_CNT, 3, consecutive tripped scans required before trip_out asserts; used only with AIE_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- trig  in  1  scan start, 1-cycle pulse; same pulse that restarts the address generator.
- aie_addr  in  7  current ID slot from the generator.
- wr  in  1  generator write window; level signal.
- mask  in  1  ID enabled, X plane checked.
- mask2  in  1  ID enabled, Y plane also checked.
- pos_x  in  DW  signed X position for aie_addr; valid while wr=1.
- pos_y  in  DW  signed Y position for aie_addr; valid while wr=1.
- lim_x  in  DW  unsigned X limit; valid while wr=1.
- lim_y  in  DW  unsigned Y limit; valid while wr=1.
- trip_clr  in  1  operator clear of the latched trip.
- trip_bm  out  64  per-ID trip bitmap of the last completed scan; bits >= MAX_ID_NUM are 0.
- trip_out  out  1  sticky interlock trip.
- first_id  out  7  ID of the first trip since the last clear; 7'h7F means none.
- scan_done  out  1  1-cycle pulse when trip_bm updates.
- scan_err  out  8  count of aborted scans; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; trip_bm=0, trip_out=0, first_id=7'h7F, scan_done=0, scan_err=0; pipeline and working bitmap cleared.

State machine:
- IDLE: trig -> SCAN and clear working bitmap cur_bm.
- SCAN:
  - Sample event = wr & ~wr_d (rising edge, registered wr_d) with mask=1 and aie_addr < MAX_ID_NUM.
  - Exactly one sample per ID, even if wr is held for many cycles.
  - Masked IDs (mask=0) never set a bit.
- SCAN -> DRAIN: once aie_addr >= MAX_ID_NUM.
- DRAIN: waits 2 cycles for the pipeline to empty, then -> DONE.
- DONE (1 cycle):
  - trip_bm <= cur_bm; scan_done=1; trip_out <= trip_out | (|cur_bm).
  - first_id <= lowest set ID in cur_bm if first_id==7'h7F.
  - Then -> IDLE.

Pipeline (2 stages, latency 2 clk from sample event to cur_bm bit set):
- Stage 1: register addr, mask2, |pos_x|, |pos_y|, lim_x, lim_y.
  - abs saturates: -2^(DW-1) -> 2^(DW-1)-1.
- Stage 2: hit = (|pos_x| > lim_x) | (mask2 & (|pos_y| > lim_y)); cur_bm[addr] |= hit.
- Equality with the limit is not a trip.

Boundary conditions:
- trig while in SCAN or DRAIN: abort; scan_err++ (saturating); cur_bm cleared; pipeline flushed; re-enter SCAN. trip_bm is not updated.
- trig in DONE: DONE completes, then the next state is SCAN, not IDLE.
- trip_clr: trip_out<=0, first_id<=7'h7F. If it coincides with DONE and |cur_bm=1, the set wins and first_id takes the new value.
- aie_addr >= MAX_ID_NUM with wr=1: ignored.

Optional Feature:
- Macro: AIE_DEBOUNCE_EN.
- Defined:
  - Each ID has a saturating counter sized for TRIP_CNT.
  - In DONE: counter increments if the ID's cur_bm bit is set, else clears to 0.
  - trip_out and first_id update only for IDs whose counter reaches TRIP_CNT.
  - trip_bm still reports raw per-scan hits.
  - trip_clr also clears all counters.
- Undefined: a single tripped scan sets trip_out; no counters are synthesized.

Test Plan:
- Reset, trig, 60 IDs all mask=1, pos_x=100, lim_x=200 -> scan_done pulse; trip_bm=0; trip_out=0; first_id=7'h7F.
- ID 5: pos_x=-300, lim_x=200; ID 12: pos_y=250, lim_y=250, mask2=1 -> trip_bm=64'h20 (equality is no trip); trip_out=1; first_id=5.
- ID 7: pos_y=900, lim_y=10, mask2=0; ID 9 out of range with mask=0 -> trip_bm=0.
- wr held high 36 cycles on ID 3 with pos_x=-2^31, lim_x=2^31-2 -> exactly one sample; bit 3 set (abs saturated).
- trig at aie_addr=30 mid-scan -> scan_err=1; no scan_done; the following full scan publishes only its own hits. trip_clr issued in the same cycle as a tripping DONE -> trip_out stays 1.
- AIE_DEBOUNCE_EN with TRIP_CNT=3: ID 2 trips in scans 1, 2, clean in 3, trips in 4, 5, 6 -> trip_out rises only at DONE of scan 6; first_id=2.
